// File: rtl/id_ex_stage_reg_pkg.sv
// id_ex_stage_reg_pkg: shared widths, EXE_CMD encodings and the control bundle
// for the ID/EX pipeline register.
`default_nettype none

package id_ex_stage_reg_pkg;

    localparam int CMD_W      = 4;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [CMD_W-1:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_t;

    typedef struct packed {
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             b;
        logic             s;
        logic [CMD_W-1:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_reg_stage_field_reg.sv
// stage_field_reg: W-bit pipeline field register.
// Priority per edge: sync active-low reset > hold > clear > load.
`default_nettype none

module stage_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (hold) begin
            q <= q;
        end else if (clear) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with freeze, flush, bubble and valid.
// Optional statistics counters enabled by macro ID_EX_STATS_EN.
`default_nettype none

module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CMD_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  bubble,
    input  logic                  id_valid,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic [CMD_W-1:0]      id_exe_cmd,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic                  id_imm,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_simm24,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_carry,
`ifdef ID_EX_STATS_EN
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      stat_flush_cnt,
    output logic [CNT_W-1:0]      stat_bubble_cnt,
    output logic [CNT_W-1:0]      stat_freeze_cnt,
`endif
    output logic                  ex_valid,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic [CMD_W-1:0]      ex_exe_cmd,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val_rn,
    output logic [DATA_W-1:0]     ex_val_rm,
    output logic                  ex_imm,
    output logic [11:0]           ex_shift_operand,
    output logic [23:0]           ex_simm24,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic                  ex_carry
);

    localparam int CTRL_W = $bits(ctrl_t) + 1;
    localparam int DATA_BUNDLE_W = 3 * DATA_W + 1 + 12 + 24 + 3 * REG_ADDR_W + 1;

    ctrl_t                    ctrl_d;
    ctrl_t                    ctrl_q;
    logic                     valid_q;
    logic                     nop_load;
    logic [DATA_BUNDLE_W-1:0] data_d;
    logic [DATA_BUNDLE_W-1:0] data_q;

    assign nop_load = flush | bubble;

    // Invalid instructions carry zero control; branches never carry an ALU
    // command, which also keeps an undriven command field from reaching EX.
    always_comb begin
        ctrl_d = CTRL_NOP;
        if (id_valid) begin
            ctrl_d.wb_en    = id_wb_en;
            ctrl_d.mem_r_en = id_mem_r_en;
            ctrl_d.mem_w_en = id_mem_w_en;
            ctrl_d.b        = id_b;
            ctrl_d.s        = id_s;
            ctrl_d.exe_cmd  = id_b ? EXE_NOP : id_exe_cmd;
        end
    end

    assign data_d = {id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand,
                     id_simm24, id_dest, id_src1, id_src2, id_carry};

    stage_field_reg #(
        .W (CTRL_W)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (freeze),
        .clear (nop_load),
        .d     ({id_valid, ctrl_d}),
        .q     ({valid_q, ctrl_q})
    );

    stage_field_reg #(
        .W (DATA_BUNDLE_W)
    ) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (freeze),
        .clear (nop_load),
        .d     (data_d),
        .q     (data_q)
    );

    assign ex_valid    = valid_q;
    assign ex_wb_en    = ctrl_q.wb_en;
    assign ex_mem_r_en = ctrl_q.mem_r_en;
    assign ex_mem_w_en = ctrl_q.mem_w_en;
    assign ex_b        = ctrl_q.b;
    assign ex_s        = ctrl_q.s;
    assign ex_exe_cmd  = ctrl_q.exe_cmd;

    assign {ex_pc, ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand,
            ex_simm24, ex_dest, ex_src1, ex_src2, ex_carry} = data_q;

`ifdef ID_EX_STATS_EN
    // Each event counts only on edges where it is the winning action.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_flush_cnt  <= '0;
            stat_bubble_cnt <= '0;
            stat_freeze_cnt <= '0;
        end else begin
            if (freeze && !(&stat_freeze_cnt))
                stat_freeze_cnt <= stat_freeze_cnt + CNT_W'(1);
            if (!freeze && flush && !(&stat_flush_cnt))
                stat_flush_cnt <= stat_flush_cnt + CNT_W'(1);
            if (!freeze && !flush && bubble && !(&stat_bubble_cnt))
                stat_bubble_cnt <= stat_bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed scenarios plus randomized traffic checked
// against a field-level reference model of the ID/EX register.
`default_nettype none

module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] simm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        carry;
    } out_t;

    logic clk = 1'b0;
    logic rst_n, freeze, flush, bubble;
    logic id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_carry;
    logic [3:0]  id_exe_cmd, id_dest, id_src1, id_src2;
    logic [31:0] id_pc, id_val_rn, id_val_rm;
    logic [11:0] id_shift_operand;
    logic [23:0] id_simm24;

    logic ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_carry;
    logic [3:0]  ex_exe_cmd, ex_dest, ex_src1, ex_src2;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_simm24;

`ifdef ID_EX_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_flush_cnt, stat_bubble_cnt, stat_freeze_cnt;
`endif

    out_t obs;
    out_t model;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .bubble(bubble),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_exe_cmd(id_exe_cmd),
        .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand), .id_simm24(id_simm24), .id_dest(id_dest),
        .id_src1(id_src1), .id_src2(id_src2), .id_carry(id_carry),
`ifdef ID_EX_STATS_EN
        .stat_clr(stat_clr), .stat_flush_cnt(stat_flush_cnt),
        .stat_bubble_cnt(stat_bubble_cnt), .stat_freeze_cnt(stat_freeze_cnt),
`endif
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_exe_cmd(ex_exe_cmd),
        .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_imm(ex_imm),
        .ex_shift_operand(ex_shift_operand), .ex_simm24(ex_simm24), .ex_dest(ex_dest),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_carry(ex_carry)
    );

    assign obs = '{valid: ex_valid, wb_en: ex_wb_en, mem_r_en: ex_mem_r_en,
                   mem_w_en: ex_mem_w_en, b: ex_b, s: ex_s, exe_cmd: ex_exe_cmd,
                   pc: ex_pc, val_rn: ex_val_rn, val_rm: ex_val_rm, imm: ex_imm,
                   shift_operand: ex_shift_operand, simm24: ex_simm24,
                   dest: ex_dest, src1: ex_src1, src2: ex_src2, carry: ex_carry};

    // What EX should hold after the coming edge, from the stage rules.
    function automatic out_t next_state(input out_t cur);
        out_t r;
        if (!rst_n) return '0;
        if (freeze) return cur;
        if (flush || bubble) return '0;
        r = '0;
        r.pc = id_pc; r.val_rn = id_val_rn; r.val_rm = id_val_rm;
        r.imm = id_imm; r.shift_operand = id_shift_operand; r.simm24 = id_simm24;
        r.dest = id_dest; r.src1 = id_src1; r.src2 = id_src2; r.carry = id_carry;
        if (id_valid) begin
            r.valid = 1'b1; r.wb_en = id_wb_en; r.mem_r_en = id_mem_r_en;
            r.mem_w_en = id_mem_w_en; r.b = id_b; r.s = id_s;
            r.exe_cmd = id_b ? 4'b0000 : id_exe_cmd;
        end
        return r;
    endfunction

    task automatic step();
        model = next_state(model);
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_inputs(input logic v);
        freeze = v; flush = v; bubble = v;
        id_valid = v; id_wb_en = v; id_mem_r_en = v; id_mem_w_en = v; id_b = v; id_s = v;
        id_imm = v; id_carry = v;
        id_exe_cmd = {4{v}}; id_dest = {4{v}}; id_src1 = {4{v}}; id_src2 = {4{v}};
        id_pc = {32{v}}; id_val_rn = {32{v}}; id_val_rm = {32{v}};
        id_shift_operand = {12{v}}; id_simm24 = {24{v}};
    endtask

    task automatic randomize_id();
        id_valid = ($urandom_range(0, 7) != 0);
        id_wb_en = 1'($urandom); id_mem_r_en = 1'($urandom); id_mem_w_en = 1'($urandom);
        id_b = ($urandom_range(0, 3) == 0); id_s = 1'($urandom);
        id_imm = 1'($urandom); id_carry = 1'($urandom);
        id_exe_cmd = 4'($urandom_range(0, 9));
        id_dest = 4'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
        id_pc = $urandom; id_val_rn = $urandom; id_val_rm = $urandom;
        id_shift_operand = 12'($urandom); id_simm24 = 24'($urandom);
    endtask

    task automatic test_reset();
        set_all_inputs(1'b1);
        rst_n = 1'b0;
`ifdef ID_EX_STATS_EN
        stat_clr = 1'b0;
`endif
        step();
        step();
        n_checks++;
        if (obs !== out_t'(0)) begin
            n_fail++; $display("FAIL reset_all_zero: got %h required 0", obs);
        end
        set_all_inputs(1'b0);
        rst_n = 1'b1;
        id_pc = 32'h104; id_exe_cmd = EXE_ADD; id_wb_en = 1'b1; id_valid = 1'b1;
        step();
        n_checks++;
        if (ex_pc !== 32'h104 || ex_exe_cmd !== 4'b0010 || ex_wb_en !== 1'b1 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_load: pc=%h cmd=%b wb=%b v=%b required pc=104 cmd=0010 wb=1 v=1",
                     ex_pc, ex_exe_cmd, ex_wb_en, ex_valid);
        end
    endtask

    task automatic test_freeze();
        randomize_id();
        id_valid = 1'b1; id_b = 1'b0; id_exe_cmd = EXE_ADD;
        step();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            id_valid = 1'b1; id_b = 1'b0; id_exe_cmd = EXE_SUB;
            step();
            n_checks++;
            if (ex_exe_cmd !== 4'b0010 || obs !== model) begin
                n_fail++; $display("FAIL freeze_hold[%0d]: cmd=%b required 0010", i, ex_exe_cmd);
            end
        end
        freeze = 1'b0;
        step();
        n_checks++;
        if (ex_exe_cmd !== 4'b0100 || obs !== model) begin
            n_fail++; $display("FAIL freeze_release: cmd=%b required 0100", ex_exe_cmd);
        end
    endtask

    task automatic test_flush();
        randomize_id();
        id_valid = 1'b1; id_mem_w_en = 1'b1; id_dest = 4'd5;
        flush = 1'b1;
        step();
        n_checks++;
        if (ex_mem_w_en !== 1'b0 || ex_dest !== 4'd0 || ex_valid !== 1'b0 || obs !== out_t'(0)) begin
            n_fail++;
            $display("FAIL flush_nop: mw=%b dest=%0d v=%b required 0 0 0", ex_mem_w_en, ex_dest, ex_valid);
        end
        flush = 1'b0;
        step();
        n_checks++;
        if (obs !== model || ex_valid !== 1'b1 || ex_dest !== 4'd5) begin
            n_fail++; $display("FAIL flush_then_load: got %h required %h", obs, model);
        end
    endtask

    task automatic test_freeze_flush();
        out_t held;
        randomize_id();
        id_valid = 1'b1;
        step();
        held = model;
        freeze = 1'b1; flush = 1'b1;
        randomize_id();
        step();
        n_checks++;
        if (obs !== held) begin
            n_fail++; $display("FAIL freeze_over_flush: got %h required %h", obs, held);
        end
        freeze = 1'b0;
        step();
        n_checks++;
        if (obs !== out_t'(0)) begin
            n_fail++; $display("FAIL flush_after_freeze: got %h required 0", obs);
        end
        flush = 1'b0;
    endtask

    task automatic test_bubble_invalid();
        randomize_id();
        id_valid = 1'b1; id_b = 1'b0; id_exe_cmd = EXE_ADC; id_wb_en = 1'b1;
        bubble = 1'b1;
        step();
        n_checks++;
        if (ex_wb_en !== 1'b0 || ex_valid !== 1'b0 || obs !== out_t'(0)) begin
            n_fail++; $display("FAIL bubble_nop: wb=%b v=%b cmd=%b required 0 0 0000",
                               ex_wb_en, ex_valid, ex_exe_cmd);
        end
        bubble = 1'b0;
        randomize_id();
        id_valid = 1'b0; id_wb_en = 1'b1; id_pc = 32'hDEAD_0040;
        step();
        n_checks++;
        if (ex_wb_en !== 1'b0 || ex_valid !== 1'b0 || ex_pc !== 32'hDEAD_0040 || obs !== model) begin
            n_fail++; $display("FAIL invalid_load: wb=%b v=%b pc=%h required 0 0 dead0040",
                               ex_wb_en, ex_valid, ex_pc);
        end
    endtask

    task automatic test_branch_cmd();
        randomize_id();
        id_valid = 1'b1; id_b = 1'b1; id_exe_cmd = EXE_EOR;
        step();
        n_checks++;
        if (ex_b !== 1'b1 || ex_exe_cmd !== 4'b0000) begin
            n_fail++; $display("FAIL branch_cmd: b=%b cmd=%b required 1 0000", ex_b, ex_exe_cmd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            randomize_id();
            rst_n  = ($urandom_range(0, 29) != 0);
            freeze = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 5) == 0);
            bubble = ($urandom_range(0, 5) == 0);
            step();
            n_checks++;
            if (obs !== model) begin
                n_fail++; $display("FAIL random[%0d]: got %h required %h", i, obs, model);
            end
        end
        rst_n = 1'b1; freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
    endtask

`ifdef ID_EX_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        n_checks++;
        if (stat_flush_cnt !== 16'd0 || stat_bubble_cnt !== 16'd0 || stat_freeze_cnt !== 16'd0) begin
            n_fail++; $display("FAIL stats_clr0: %0d %0d %0d required 0 0 0",
                               stat_flush_cnt, stat_bubble_cnt, stat_freeze_cnt);
        end
        flush = 1'b1;
        for (int i = 0; i < 3; i++) step();
        flush = 1'b0; bubble = 1'b1;
        for (int i = 0; i < 2; i++) step();
        bubble = 1'b0; freeze = 1'b1; flush = 1'b1;
        step();
        freeze = 1'b0; flush = 1'b0;
        step();
        n_checks++;
        if (stat_flush_cnt !== 16'd3 || stat_bubble_cnt !== 16'd2 || stat_freeze_cnt !== 16'd1) begin
            n_fail++; $display("FAIL stats_counts: flush=%0d bubble=%0d freeze=%0d required 3 2 1",
                               stat_flush_cnt, stat_bubble_cnt, stat_freeze_cnt);
        end
        stat_clr = 1'b1; flush = 1'b1;
        step();
        stat_clr = 1'b0;
        n_checks++;
        if (stat_flush_cnt !== 16'd0 || stat_bubble_cnt !== 16'd0 || stat_freeze_cnt !== 16'd0) begin
            n_fail++; $display("FAIL stats_clr: %0d %0d %0d required 0 0 0",
                               stat_flush_cnt, stat_bubble_cnt, stat_freeze_cnt);
        end
        for (int i = 0; i < 16'hFFFE; i++) step();
        n_checks++;
        if (stat_flush_cnt !== 16'hFFFE) begin
            n_fail++; $display("FAIL stats_preload: %h required fffe", stat_flush_cnt);
        end
        for (int i = 0; i < 3; i++) step();
        flush = 1'b0;
        n_checks++;
        if (stat_flush_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL stats_saturate: %h required ffff", stat_flush_cnt);
        end
    endtask
`endif

    initial begin
        model = '0;
        test_reset();
        test_freeze();
        test_flush();
        test_freeze_flush();
        test_bubble_invalid();
        test_branch_cmd();
        test_random();
`ifdef ID_EX_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
